// File: rtl/timer_pkg.sv
// Shared definitions for the compare-timer interrupt controller.
// Holds the register map (word offsets within a channel), CTRL bit
// positions, the maximum channel count and the per-channel write bundle
// produced by the top-level bus decode.
package timer_pkg;

  localparam int NCH_MAX = 4;

  // Register index = REQ_ADDR[3:2]
  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_W        = 3;

  // One channel's decoded write strobes plus shared write data
  typedef struct packed {
    logic        wr_cmp;
    logic        wr_period;
    logic        wr_ctrl;
    logic        clr_pend;
    logic [31:0] wdata;
  } chan_wr_t;

endpackage

// File: rtl/timer_cmp_chan.sv
// One compare channel: CMP/PERIOD/CTRL/PEND state, wrap-safe compare,
// periodic reload and pending flag.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   time_counter      free-running microsecond count
//   wr_cmp/wr_period/wr_ctrl/clr_pend  decoded bus strobes for this channel
//   wdata             bus write data
//   cmp, period, ctrl, pend  current register contents (for readback / IRQ)
module timer_cmp_chan
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       time_counter,
  input  logic              wr_cmp,
  input  logic              wr_period,
  input  logic              wr_ctrl,
  input  logic              clr_pend,
  input  logic [31:0]       wdata,
  output logic [31:0]       cmp,
  output logic [31:0]       period,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pend
);

  logic [31:0]       cmp_q, cmp_d;
  logic [31:0]       period_q, period_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pend_q, pend_d;
  logic [31:0]       diff;
  logic              fire;

  // Sign of the modular difference decides "reached", so the compare keeps
  // working across the 32-bit counter wrap.
  assign diff = time_counter - cmp_q;
  assign fire = ctrl_q[CTRL_EN] & ~diff[31];

  always_comb begin
    cmp_d    = cmp_q;
    period_d = period_q;
    ctrl_d   = ctrl_q;
    pend_d   = pend_q;

    if (fire) begin
      pend_d = 1'b1;
      // A reload still in the past fires again next cycle; no skipping.
      if (ctrl_q[CTRL_PERIODIC] && (period_q != 32'd0))
        cmp_d = cmp_q + period_q;
      else
        ctrl_d[CTRL_EN] = 1'b0;
    end

    // W1C loses to a same-cycle fire
    if (clr_pend && wdata[0] && !fire)
      pend_d = 1'b0;

    // Bus writes override the fire-side update of the same field
    if (wr_cmp)    cmp_d    = wdata;
    if (wr_period) period_d = wdata;
    if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q    <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      cmp_q    <= cmp_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
    end
  end

  assign cmp    = cmp_q;
  assign period = period_q;
  assign ctrl   = ctrl_q;
  assign pend   = pend_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Multi-channel compare timer with a simple single-cycle register bus and
// a level interrupt plus lowest-index source ID.
// Ports:
//   CLK, RESETN       clock, async active-low reset
//   TIME_COUNTER      free-running microsecond count
//   REQ_*             request: valid, write enable, byte addr ([5:4] chan,
//                     [3:2] reg), write data; REQ_READY is always 1
//   RESP_VALID/RDATA  response one cycle after every request (0 on writes)
//   IRQ, IRQ_ID       registered OR of PEND&IE and lowest firing channel
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] TIME_COUNTER,
  input  logic        REQ_VALID,
  input  logic        REQ_WE,
  input  logic [5:0]  REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        REQ_READY,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic        IRQ,
  output logic [1:0]  IRQ_ID
);

  logic [1:0] req_chan;
  logic [1:0] req_reg;
  logic       unused_addr;

  assign req_chan    = REQ_ADDR[5:4];
  assign req_reg     = REQ_ADDR[3:2];
  assign unused_addr = ^REQ_ADDR[1:0];
  assign REQ_READY   = 1'b1;

  // Padded to NCH_MAX; absent channels read as zero and never interrupt.
  logic [NCH_MAX-1:0][31:0]       cmp_all;
  logic [NCH_MAX-1:0][31:0]       period_all;
  logic [NCH_MAX-1:0][CTRL_W-1:0] ctrl_all;
  logic [NCH_MAX-1:0]             pend_all;

  for (genvar i = 0; i < NCH_MAX; i++) begin : g_ch
    if (i < NCH) begin : g_on
      chan_wr_t wr;

      always_comb begin
        wr       = '0;
        wr.wdata = REQ_WDATA;
        if (REQ_VALID && REQ_WE && (req_chan == 2'(i))) begin
          case (req_reg)
            REG_CMP:    wr.wr_cmp    = 1'b1;
            REG_PERIOD: wr.wr_period = 1'b1;
            REG_CTRL:   wr.wr_ctrl   = 1'b1;
            REG_STATUS: wr.clr_pend  = 1'b1;
          endcase
        end
      end

      timer_cmp_chan u_chan (
        .clk          (CLK),
        .rst_n        (RESETN),
        .time_counter (TIME_COUNTER),
        .wr_cmp       (wr.wr_cmp),
        .wr_period    (wr.wr_period),
        .wr_ctrl      (wr.wr_ctrl),
        .clr_pend     (wr.clr_pend),
        .wdata        (wr.wdata),
        .cmp          (cmp_all[i]),
        .period       (period_all[i]),
        .ctrl         (ctrl_all[i]),
        .pend         (pend_all[i])
      );
    end else begin : g_off
      assign cmp_all[i]    = '0;
      assign period_all[i] = '0;
      assign ctrl_all[i]   = '0;
      assign pend_all[i]   = 1'b0;
    end
  end

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [1:0]  irq_id_q, irq_id_d;
  logic [NCH_MAX-1:0] irq_vec;

  always_comb begin
    resp_valid_d = REQ_VALID;
    rdata_d      = '0;
    if (REQ_VALID && !REQ_WE) begin
      case (req_reg)
        REG_CMP:    rdata_d = cmp_all[req_chan];
        REG_PERIOD: rdata_d = period_all[req_chan];
        REG_CTRL:   rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_all[req_chan]};
        REG_STATUS: rdata_d = {31'd0, pend_all[req_chan]};
      endcase
    end
  end

  // Priority encoder: scan high to low so the lowest index wins.
  always_comb begin
    irq_id_d = 2'd0;
    for (int i = 0; i < NCH_MAX; i++)
      irq_vec[i] = pend_all[i] & ctrl_all[i][CTRL_IE];
    irq_d = |irq_vec;
    for (int i = NCH_MAX - 1; i >= 0; i--)
      if (irq_vec[i]) irq_id_d = 2'(i);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= 2'd0;
    end else begin
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
    end
  end

  assign RESP_VALID = resp_valid_q;
  assign RESP_RDATA = rdata_q;
  assign IRQ        = irq_q;
  assign IRQ_ID     = irq_id_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboarded bench for timer_irq_ctrl: a driver applies one stimulus per
// clock, predicts the response from a behavioural register model and
// queues it; a monitor compares responses and IRQ every cycle.
module tb_timer_irq_ctrl;

  localparam int NCH = 4;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [31:0] TIME_COUNTER = '0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [5:0]  REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        REQ_READY;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        IRQ;
  logic [1:0]  IRQ_ID;

  timer_irq_ctrl #(.NCH(NCH)) dut (
    .CLK(CLK), .RESETN(RESETN), .TIME_COUNTER(TIME_COUNTER),
    .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID),
    .RESP_RDATA(RESP_RDATA), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model of the register file
  logic [31:0] m_cmp [NCH];
  logic [31:0] m_per [NCH];
  logic        m_en [NCH];
  logic        m_pd [NCH];
  logic        m_ie [NCH];
  logic        m_pend [NCH];

  logic [31:0] exp_q [$];
  logic        exp_irq = 1'b0;
  logic [1:0]  exp_id = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cmp[c] = '0; m_per[c] = '0; m_en[c] = 1'b0;
      m_pd[c] = 1'b0; m_ie[c] = 1'b0; m_pend[c] = 1'b0;
    end
    exp_irq = 1'b0;
    exp_id  = 2'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    int c;
    c = int'(a[5:4]);
    if (c >= NCH) return 32'd0;
    case (a[3:2])
      2'd0:    return m_cmp[c];
      2'd1:    return m_per[c];
      2'd2:    return {29'd0, m_ie[c], m_pd[c], m_en[c]};
      default: return {31'd0, m_pend[c]};
    endcase
  endfunction

  // One clock of stimulus; the model advances to the state after the edge.
  task automatic cyc(input logic [31:0] tc, input logic v, input logic we,
                     input logic [5:0] a, input logic [31:0] d);
    logic [31:0] diff;
    logic fire, hit;
    @(negedge CLK);
    TIME_COUNTER = tc; REQ_VALID = v; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = d;
    if (v) exp_q.push_back(we ? 32'd0 : m_read(a));
    // IRQ after this edge reflects PEND/IE as they stand before it
    exp_irq = 1'b0; exp_id = 2'd0;
    for (int c = NCH - 1; c >= 0; c--)
      if (m_pend[c] && m_ie[c]) begin exp_irq = 1'b1; exp_id = 2'(c); end
    for (int c = 0; c < NCH; c++) begin
      diff = tc - m_cmp[c];
      fire = m_en[c] && ($signed(diff) >= 0);
      hit  = v && we && (int'(a[5:4]) == c);
      if (fire) begin
        m_pend[c] = 1'b1;
        if (m_pd[c] && m_per[c] != 0) m_cmp[c] = m_cmp[c] + m_per[c];
        else m_en[c] = 1'b0;
      end
      if (hit) begin
        case (a[3:2])
          2'd0: m_cmp[c] = d;
          2'd1: m_per[c] = d;
          2'd2: begin m_ie[c] = d[2]; m_pd[c] = d[1]; m_en[c] = d[0]; end
          default: if (d[0] && !fire) m_pend[c] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic wr(input logic [31:0] tc, input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d);
    cyc(tc, 1'b1, 1'b1, {ch, r, 2'b00}, d);
  endtask
  task automatic rd(input logic [31:0] tc, input logic [1:0] ch, input logic [1:0] r);
    cyc(tc, 1'b1, 1'b0, {ch, r, 2'b00}, 32'd0);
  endtask
  task automatic idle(input logic [31:0] tc);
    cyc(tc, 1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  // Monitor: response (if one is due) and IRQ every cycle
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge CLK); #1;
      chk("resp_valid", 32'(RESP_VALID), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (RESP_VALID) chk("resp_rdata", RESP_RDATA, e);
      end
      chk("irq", 32'({IRQ_ID, IRQ}), 32'({exp_id, exp_irq}));
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tc, d;
    logic [1:0] ch, r;
    model_reset();
    #1;
    chk("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    chk("rst_irq", 32'({IRQ_ID, IRQ}), 32'd0);
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;

    // Reset state of every register
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 4; k++) rd(0, 2'(c), 2'(k));

    // One-shot on channel 0
    wr(0, 0, 0, 100);
    wr(0, 0, 2, 5);
    for (int t = 95; t <= 105; t++) idle(t);
    chk("oneshot_irq_id", 32'({IRQ_ID, IRQ}), 32'({2'd0, 1'b1}));
    rd(105, 0, 2);
    rd(105, 0, 3);
    wr(105, 0, 3, 1);
    idle(106);
    idle(106);
    chk("oneshot_cleared", 32'(IRQ), 32'd0);

    // Periodic on channel 1: fires at 10, 15, 20
    wr(0, 1, 0, 10);
    wr(0, 1, 1, 5);
    wr(0, 1, 2, 7);
    for (int t = 0; t <= 22; t++) idle(t);
    rd(22, 1, 0);
    wr(22, 1, 2, 4);
    wr(22, 1, 3, 1);

    // Wrap on channel 2
    wr(32'hFFFF_FFF0, 2, 0, 8);
    wr(32'hFFFF_FFF0, 2, 2, 5);
    for (int t = 0; t <= 25; t++) idle(32'hFFFF_FFF0 + 32'(t));
    rd(32'h10, 2, 2);
    wr(32'h10, 2, 3, 1);

    // Channels 1 and 3 fire together
    wr(0, 1, 0, 50);
    wr(0, 1, 2, 5);
    wr(0, 3, 0, 50);
    wr(0, 3, 2, 5);
    idle(50);
    idle(51);
    idle(51);
    chk("prio_id_1", 32'({IRQ_ID, IRQ}), 32'({2'd1, 1'b1}));
    wr(51, 1, 3, 1);
    idle(51);
    idle(51);
    chk("prio_id_3", 32'({IRQ_ID, IRQ}), 32'({2'd3, 1'b1}));

    // Enable with CMP already past, then W1C colliding with a new fire
    wr(10, 0, 0, 5);
    wr(10, 0, 2, 5);
    idle(10);
    wr(10, 0, 0, 200);
    wr(10, 0, 2, 5);
    idle(199);
    wr(200, 0, 3, 1);
    rd(200, 0, 3);

    // Periodic reload landing in the past catches up one step per cycle
    wr(20, 2, 0, 0);
    wr(20, 2, 1, 3);
    wr(20, 2, 2, 3);
    for (int k = 0; k < 10; k++) rd(20, 2, 0);
    rd(20, 2, 2);

    // Periodic with PERIOD = 0 behaves as one-shot
    wr(10, 3, 1, 0);
    wr(10, 3, 0, 5);
    wr(10, 3, 2, 3);
    idle(10);
    rd(10, 3, 2);
    rd(10, 3, 0);

    // Reset between a read request and its response
    rd(20, 0, 0);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 6'h04; REQ_WDATA = '0;
    model_reset();
    #2 RESETN = 1'b0;
    #1;
    chk("rst_drop_resp", 32'(RESP_VALID), 32'd0);
    chk("rst_drop_rdata", RESP_RDATA, 32'd0);
    chk("rst_drop_irq", 32'({IRQ_ID, IRQ}), 32'd0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RESETN = 1'b1;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 4; k++) rd(0, 2'(c), 2'(k));

    // Randomised traffic against the model
    tc = 32'd0;
    for (int n = 0; n < 400; n++) begin
      tc = tc + $urandom_range(0, 3);
      ch = 2'($urandom_range(0, 3));
      r  = 2'($urandom_range(0, 3));
      case (r)
        2'd0:    d = tc + $urandom_range(0, 24) - 32'd4;
        2'd1:    d = $urandom_range(0, 6);
        2'd2:    d = $urandom_range(0, 7);
        default: d = $urandom_range(0, 1);
      endcase
      if ($urandom_range(0, 3) == 0) idle(tc);
      else cyc(tc, 1'b1, 1'($urandom_range(0, 1)), {ch, r, 2'($urandom_range(0, 3))}, d);
    end
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 4; k++) rd(tc, 2'(c), 2'(k));

    idle(tc);
    idle(tc);
    @(posedge CLK); #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of compare channels, legal 1..4.
REQ-002 SHALL have port CLK, input, 1, sole clock.
REQ-003 SHALL have port RESETN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port TIME_COUNTER, input, 32, free-running microsecond count from timer.
REQ-005 SHALL have port REQ_VALID, input, 1, bus request strobe.
REQ-006 SHALL have port REQ_WE, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port REQ_ADDR, input, 6, byte address; [5:4] = channel, [3:2] = register.
REQ-008 SHALL have port REQ_WDATA, input, 32, write data.
REQ-009 SHALL have port REQ_READY, output, 1, constant 1.
REQ-010 SHALL have port RESP_VALID, output, 1, response strobe.
REQ-011 SHALL have port RESP_RDATA, output, 32, read data; 0 on writes.
REQ-012 SHALL have port IRQ, output, 1, level interrupt.
REQ-013 SHALL have port IRQ_ID, output, 2, lowest-index channel asserting IRQ.

Function
REQ-014 Per-channel registers SHALL be: 0 CMP[31:0]; 1 PERIOD[31:0]; 2 CTRL {IE[2], PERIODIC[1], EN[0]}; 3 STATUS {PEND[0]}, write-1-to-clear. All other bits SHALL read 0.
REQ-015 Accesses to channel >= NCH SHALL have no effect, read 0, and still respond.
REQ-016 Every accepted request SHALL produce RESP_VALID exactly one cycle later, with back-to-back requests allowed.
REQ-017 Channel i SHALL fire in a cycle where EN=1 and $signed(TIME_COUNTER - CMP) >= 0 (wrap-safe 32-bit difference).
REQ-018 On fire: PEND <= 1; if PERIODIC=1 and PERIOD != 0, CMP <= CMP + PERIOD (mod 2^32) and EN stays 1; otherwise EN <= 0.
REQ-019 Multiple channels SHALL be able to fire in the same cycle, each independently.
REQ-020 A fire SHALL take priority over a same-cycle W1C of PEND, leaving PEND = 1.
REQ-021 A bus write to CMP or CTRL SHALL take priority over a same-cycle fire update of that field; PEND is still set.
REQ-022 If a periodic reload lands in the past, firing SHALL repeat on subsequent cycles until caught up; no skipping.
REQ-023 IRQ SHALL be registered and equal OR over i of (PEND[i] & IE[i]), one cycle after PEND/IE change.
REQ-024 IRQ_ID SHALL be registered with IRQ: the lowest i with PEND & IE, else 0.
REQ-025 Writing EN=1 with CMP already in the past SHALL fire on the next cycle.

Reset
REQ-026 While RESETN = 0 (asynchronous assertion), SHALL hold: all CMP, PERIOD, CTRL, PEND = 0; IRQ = 0, IRQ_ID = 0, RESP_VALID = 0, RESP_RDATA = 0.
REQ-027 Reset asserted mid-transaction SHALL drop any pending response; no response SHALL follow deassertion.
REQ-028 Registers SHALL be updated on the first CLK edge after deassertion.

Structure
REQ-029 Register offsets, CTRL bit positions and NCH_MAX = 4 SHALL live in a shared package, timer_pkg.
REQ-030 Per-channel compare/reload/pending logic SHALL be one sub-module, timer_cmp_chan, instantiated NCH times.
REQ-031 The bus decode and IRQ priority encoder SHALL reside in the top level.

Verification
REQ-032 One-shot: CMP = 100, CTRL = 0x5, TIME_COUNTER ramps 95..105 -> PEND set at 100, IRQ = 1 at 101, IRQ_ID = 0, EN reads 0; W1C STATUS -> IRQ = 0 next cycle.
REQ-033 Periodic: CMP = 10, PERIOD = 5, CTRL = 0x7 -> fires at 10, 15, 20; CMP reads 25.
REQ-034 Wrap: TIME_COUNTER = 0xFFFFFFF0, CMP = 0x00000008 -> no fire until the counter wraps to 8.
REQ-035 Priority: channels 1 and 3 fire together, both IE -> IRQ_ID = 1; clear ch1 -> IRQ_ID = 3.
REQ-036 Collision: W1C of PEND in the same cycle as a new fire -> PEND reads 1.
REQ-037 Reset: RESETN pulsed low between a read request and its response -> no RESP_VALID; all registers read 0 afterwards.
